f1_race_ctrl: RTL and testbench
===============================

Name: f1_race_ctrl

Overview:
Unified race-start controller for the F1 lights game. It owns a single shared tick prescaler and one down-counter. These sequence the 8-light build-up and then the random hold before lights-out. It then measures driver reaction time in ticks, with jump-start detection. It replaces ad-hoc muxing between the second-timer and delay paths: the lfsr output feeds `rnd`, and `data_out` drives the light bar.

Parameters:
WIDTH, 7, bit width of random hold delay `rnd` / hold counter
TICK_W, 16, bit width of prescaler divider
RT_WIDTH, 12, bit width of reaction-time counter

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
trigger  input  1  start request; rising edge used
react  input  1  driver button; rising edge used
tick_div  input  TICK_W  prescaler: one tick every tick_div+1 cycles
rnd  input  WIDTH  random hold length in ticks, sampled once per race
data_out  output  8  light bar, bit0 = first light
react_time  output  RT_WIDTH  last result, held until next result
valid  output  1  one-cycle pulse when react_time/jump_start update
jump_start  output  1  high if last race ended by early press; held
busy  output  1  high in LIGHTS, HOLD, GO

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, data_out=0, react_time=0, valid=0, jump_start=0, prescaler=0, counters=0, trig_q=react_q=0.
- Edge detect: trig_e = trigger & ~trig_q; react_e = react & ~react_q. trig_q and react_q are registered every cycle. No extra latency.
- Prescaler cnt:
  - Runs only in LIGHTS/HOLD/GO.
  - tick=1 when cnt==tick_div, then cnt<=0; else cnt++.
  - Forced to 0 on every state entry.
  - tick_div=0 gives a tick every cycle.
- States: IDLE, LIGHTS, HOLD, GO, DONE.
- IDLE/DONE:
  - On trig_e: state<=LIGHTS, data_out<=8'h01, jump_start<=0.
  - react_e is ignored. react_time is held.
- LIGHTS:
  - On tick: data_out<={data_out[6:0],1'b1}.
  - On the tick where data_out==8'h7F: data_out<=8'hFF, state<=HOLD, hold<=(rnd==0)?1:rnd.
  - rnd is sampled only in that cycle.
- HOLD:
  - On tick: hold<=hold-1.
  - On the tick where hold==1: data_out<=8'h00, state<=GO, rt<=0.
- GO:
  - On tick: rt<=rt+1, saturating at 2^RT_WIDTH-1.
  - On react_e: react_time<=rt (value before any same-cycle increment), valid<=1, state<=DONE.
  - react_e has priority over tick.
- Jump start: react_e in LIGHTS or HOLD gives the following, taking priority over tick:
  - state<=DONE, data_out<=8'h00, jump_start<=1
  - react_time<=all ones, valid<=1
- trig_e in LIGHTS/HOLD/GO is ignored; the race is not restarted.
- valid is high for exactly one cycle, the cycle after the capturing edge.
- busy is combinational from state.
- rst mid-race returns everything to reset values in the next cycle, regardless of state.
- Timing with tick_div=0:
  - trig_e to data_out=01: 1 cycle.
  - 01 to FF: 7 cycles.
  - FF to 00: max(rnd,1) cycles.

Optional Feature:
F1_BEST_TIME_EN:
- When defined, adds output port best_time [RT_WIDTH-1:0].
- best_time is reset to all ones.
- On each non-jump valid result, best_time<=min(best_time, react_time_new).
- Jump starts never update best_time.
- When undefined, the port and its register are absent and behaviour is otherwise identical.

Test Plan:
- tick_div=0, rnd=5, trig_e at cycle 0 -> data_out=01 at c1, 03 at c2, ..., FF at c8, 00 at c13; busy high c1..; valid=0.
- Continuing: react_e at c16 -> react_time=3, valid=1 only at c17, state DONE, jump_start=0, busy=0.
- tick_div=3, rnd=0 -> each light step every 4 cycles; hold treated as 1 tick (4 cycles) before 00.
- react_e while data_out=07 -> next cycle data_out=00, jump_start=1, react_time=12'hFFF, valid pulse; second trig_e restarts, clears jump_start.
- rst asserted during HOLD (data_out=FF) -> next cycle data_out=00, state IDLE, react_time=0; react_e then ignored; trig_e during GO ignored.
- F1_BEST_TIME_EN: results 9, 4, jump, 6 -> best_time FFF→9→4→4→4.

Source files
------------

// File: rtl/f1_race_ctrl.sv
// f1_race_ctrl: race-start controller for the F1 lights game.
// One shared tick prescaler drives three phases. The light bar builds up
// over 8 ticks, then a random hold runs, then the reaction time is
// counted in ticks. Pressing early is reported as a jump start.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   trigger           start request (rising edge)
//   react             driver button (rising edge)
//   tick_div          one tick every tick_div+1 cycles
//   rnd               hold length in ticks (0 treated as 1), sampled at FF
//   data_out          light bar, bit0 = first light
//   react_time        last result, held until the next one
//   valid             one-cycle pulse when react_time/jump_start update
//   jump_start        last race ended by an early press
//   busy              high while in LIGHTS, HOLD or GO (combinational)
//   best_time         best non-jump result; only with F1_BEST_TIME_EN
//
// Optional feature macro: F1_BEST_TIME_EN (adds best_time).
module f1_race_ctrl #(
  parameter int unsigned WIDTH    = 7,
  parameter int unsigned TICK_W   = 16,
  parameter int unsigned RT_WIDTH = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trigger,
  input  logic                react,
  input  logic [TICK_W-1:0]   tick_div,
  input  logic [WIDTH-1:0]    rnd,
  output logic [7:0]          data_out,
  output logic [RT_WIDTH-1:0] react_time,
  output logic                valid,
  output logic                jump_start,
  output logic                busy
`ifdef F1_BEST_TIME_EN
  ,
  output logic [RT_WIDTH-1:0] best_time
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LIGHTS = 3'd1,
    S_HOLD   = 3'd2,
    S_GO     = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          data_q, data_d;
  logic [TICK_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]    hold_q, hold_d;
  logic [RT_WIDTH-1:0] rt_q, rt_d;
  logic [RT_WIDTH-1:0] rtime_q, rtime_d;
  logic                valid_q, valid_d;
  logic                jump_q, jump_d;
  logic                trig_q, react_q;
`ifdef F1_BEST_TIME_EN
  logic [RT_WIDTH-1:0] best_q, best_d;
`endif

  logic trig_e, react_e, active, tick;

  assign trig_e  = trigger & ~trig_q;
  assign react_e = react & ~react_q;
  assign active  = (state_q == S_LIGHTS) || (state_q == S_HOLD) || (state_q == S_GO);
  assign tick    = active && (cnt_q == tick_div);

  // State register and all output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= 8'h00;
      cnt_q   <= '0;
      hold_q  <= '0;
      rt_q    <= '0;
      rtime_q <= '0;
      valid_q <= 1'b0;
      jump_q  <= 1'b0;
      trig_q  <= 1'b0;
      react_q <= 1'b0;
`ifdef F1_BEST_TIME_EN
      best_q  <= '1;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      rt_q    <= rt_d;
      rtime_q <= rtime_d;
      valid_q <= valid_d;
      jump_q  <= jump_d;
      trig_q  <= trigger;
      react_q <= react;
`ifdef F1_BEST_TIME_EN
      best_q  <= best_d;
`endif
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    hold_d  = hold_q;
    rt_d    = rt_q;
    rtime_d = rtime_q;
    valid_d = 1'b0;
    jump_d  = jump_q;
`ifdef F1_BEST_TIME_EN
    best_d  = best_q;
`endif

    // An early press beats any tick in the same cycle.
    if ((state_q == S_LIGHTS || state_q == S_HOLD) && react_e) begin
      state_d = S_DONE;
      data_d  = 8'h00;
      jump_d  = 1'b1;
      rtime_d = '1;
      valid_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (trig_e) begin
            state_d = S_LIGHTS;
            data_d  = 8'h01;
            jump_d  = 1'b0;
          end
        end
        S_LIGHTS: begin
          if (tick) begin
            data_d = {data_q[6:0], 1'b1};
            if (data_q == 8'h7F) begin
              state_d = S_HOLD;
              hold_d  = (rnd == '0) ? WIDTH'(1) : rnd;
            end
          end
        end
        S_HOLD: begin
          if (tick) begin
            hold_d = hold_q - WIDTH'(1);
            if (hold_q == WIDTH'(1)) begin
              state_d = S_GO;
              data_d  = 8'h00;
              rt_d    = '0;
            end
          end
        end
        S_GO: begin
          // Capture the pre-increment count; the press wins over a tick.
          if (react_e) begin
            state_d = S_DONE;
            rtime_d = rt_q;
            valid_d = 1'b1;
`ifdef F1_BEST_TIME_EN
            if (rt_q < best_q) best_d = rt_q;
`endif
          end else if (tick && (rt_q != '1)) begin
            rt_d = rt_q + RT_WIDTH'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Prescaler restarts on every state entry and idles outside a race.
    cnt_d = '0;
    if (active && (state_d == state_q) && !tick) cnt_d = cnt_q + TICK_W'(1);
  end

  assign data_out   = data_q;
  assign react_time = rtime_q;
  assign valid      = valid_q;
  assign jump_start = jump_q;
  assign busy       = active;
`ifdef F1_BEST_TIME_EN
  assign best_time  = best_q;
`endif

endmodule

// File: tb/tb_f1_race_ctrl.sv
// Testbench for f1_race_ctrl: directed and randomized races checked against
// an event-time model of the race (light step times, lights-out time, tick
// count at the press), not a cycle-by-cycle copy of the controller.
module tb_f1_race_ctrl;
  localparam int unsigned WIDTH    = 7;
  localparam int unsigned TICK_W   = 16;
  localparam int unsigned RT_WIDTH = 12;
  localparam int RT_MAX = (1 << RT_WIDTH) - 1;

  logic                clk = 1'b0;
  logic                rst, trigger, react;
  logic [TICK_W-1:0]   tick_div;
  logic [WIDTH-1:0]    rnd;
  logic [7:0]          data_out;
  logic [RT_WIDTH-1:0] react_time;
  logic                valid, jump_start, busy;
`ifdef F1_BEST_TIME_EN
  logic [RT_WIDTH-1:0] best_time;
  int                  exp_best;
`endif

  int total = 0;
  int bad   = 0;
  int exp_rt   = 0;
  int exp_jump = 0;

  f1_race_ctrl #(.WIDTH(WIDTH), .TICK_W(TICK_W), .RT_WIDTH(RT_WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .trigger    (trigger),
    .react      (react),
    .tick_div   (tick_div),
    .rnd        (rnd),
    .data_out   (data_out),
    .react_time (react_time),
    .valid      (valid),
    .jump_start (jump_start),
    .busy       (busy)
`ifdef F1_BEST_TIME_EN
    ,
    .best_time  (best_time)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks every output against the model's held result values.
  task automatic chk_idle(input string tag);
    chk({tag, "_data"}, int'(data_out), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_rtime"}, int'(react_time), exp_rt);
    chk({tag, "_jump"}, int'(jump_start), exp_jump);
`ifdef F1_BEST_TIME_EN
    chk({tag, "_best"}, int'(best_time), exp_best);
`endif
  endtask

  // One race: trigger sampled at edge 0, press first sampled at edge p.
  // Lights step every L=d+1 cycles from cycle 1; lights out at 1+(7+H)*L.
  task automatic run_race(input string tag, input int d, input int r, input int p);
    int L, H, go_t, n, exp_d;
    bit jump;
    L    = d + 1;
    H    = (r == 0) ? 1 : r;
    go_t = 1 + (7 + H) * L;
    jump = (p < go_t);
    tick_div = TICK_W'(d);
    rnd      = WIDTH'(r);
    trigger  = 1'b0;
    react    = 1'b0;
    step();
    trigger = 1'b1;
    for (int e = 0; e <= p + 2; e++) begin
      int k;
      step();
      k = e + 1;
      if (k <= p) begin
        n = 1 + (k - 1) / L;
        if (k >= go_t)  exp_d = 0;
        else if (n >= 8) exp_d = 255;
        else exp_d = (1 << n) - 1;
        chk({tag, "_data"}, int'(data_out), exp_d);
        chk({tag, "_busy"}, int'(busy), 1);
        chk({tag, "_valid"}, int'(valid), 0);
        chk({tag, "_jump_clr"}, int'(jump_start), 0);
        chk({tag, "_rtime_held"}, int'(react_time), exp_rt);
      end else if (k == p + 1) begin
        exp_jump = jump ? 1 : 0;
        if (jump) exp_rt = RT_MAX;
        else begin
          exp_rt = (p - go_t) / L;
          if (exp_rt > RT_MAX) exp_rt = RT_MAX;
`ifdef F1_BEST_TIME_EN
          if (exp_rt < exp_best) exp_best = exp_rt;
`endif
        end
        chk({tag, "_res_data"}, int'(data_out), 0);
        chk({tag, "_res_busy"}, int'(busy), 0);
        chk({tag, "_res_valid"}, int'(valid), 1);
        chk({tag, "_res_rtime"}, int'(react_time), exp_rt);
        chk({tag, "_res_jump"}, int'(jump_start), exp_jump);
`ifdef F1_BEST_TIME_EN
        chk({tag, "_res_best"}, int'(best_time), exp_best);
`endif
      end else begin
        chk_idle({tag, "_after"});
      end
      // Inputs for edge e+1: trigger edges mid-race must be ignored,
      // rnd may change once the hold has been loaded.
      trigger = (e + 1 <= p) ? 1'($urandom) : 1'b0;
      react   = (e + 1 >= p);
      if (e + 1 > 7 * L) rnd = WIDTH'($urandom);
    end
    react   = 1'b0;
    trigger = 1'b0;
    step();
  endtask

  initial begin
    int d, r, hl, p;
    rst = 1'b1;
    trigger = 1'b0;
    react = 1'b0;
    tick_div = '0;
    rnd = '0;
`ifdef F1_BEST_TIME_EN
    exp_best = RT_MAX;
`endif
    step();
    step();
    chk_idle("reset");
    rst = 1'b0;

    // Presses in IDLE are ignored.
    for (int i = 0; i < 6; i++) begin
      react = 1'($urandom);
      step();
      chk_idle("idle_react");
    end
    react = 1'b0;

    // tick_div=0, rnd=5: FF at c8, 00 at c13, press at c16 -> 3.
    run_race("basic", 0, 5, 16);
    // tick_div=3, rnd=0: hold of one tick.
    run_race("div3_rnd0", 3, 0, 1 + 8 * 4 + 9);
    // Press while 07 is shown -> jump start.
    run_race("jump07", 0, 5, 3);
    // Restart after a jump clears jump_start; results 9, 4, jump, 6.
    run_race("res9", 0, 2, 19);
    run_race("res4", 0, 2, 14);
    run_race("resjump", 0, 2, 5);
    run_race("res6", 0, 2, 16);
    // Press exactly at lights-out -> 0, and saturation of the counter.
    run_race("zero", 1, 3, 1 + 10 * 2);
    run_race("sat", 0, 1, 9 + RT_MAX + 6);

    // Randomized races.
    for (int i = 0; i < 10; i++) begin
      d = int'($urandom_range(0, 3));
      r = int'($urandom_range(0, 12));
      hl = 1 + (7 + ((r == 0) ? 1 : r)) * (d + 1);
      p = int'($urandom_range(1, hl + 25));
      run_race("rand", d, r, p);
    end

    // Reset during HOLD returns everything to reset values.
    tick_div = '0;
    rnd = WIDTH'(10);
    trigger = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      trigger = 1'b0;
    end
    chk("hold_data", int'(data_out), 255);
    chk("hold_busy", int'(busy), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_rt = 0;
    exp_jump = 0;
`ifdef F1_BEST_TIME_EN
    exp_best = RT_MAX;
`endif
    chk_idle("rst_hold");
    react = 1'b1;
    step();
    chk_idle("rst_react1");
    react = 1'b0;
    step();
    chk_idle("rst_react2");

    // Full race after the mid-race reset still works.
    run_race("post_rst", 2, 4, 1 + 11 * 3 + 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
